arm_ctrl_fsm: RTL and testbench
===============================

Name: arm_ctrl_fsm

Overview:
Multi-cycle control sequencer for the single-issue ARM core. Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM and WRITEBACK. Holds the instruction register that feeds the combinational instruction decoder, and gates the decoder's write-enables so register file, PC and CPSR commit only in WRITEBACK. Handles memory request/acknowledge handshakes with timeout, halt requests, and fault reporting.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ack/dmem_ack before fault (≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_ack  input  1  fetch data valid
imem_rdata  input  32  fetched instruction
inst  output  32  instruction register, drives decoder
cond_pass  input  1  condition-check result for inst
dec_rd_we  input  1  decoder rd write-enable
dec_pc_we  input  1  decoder PC write-enable
dec_cpsr_we  input  1  decoder CPSR write-enable
rf_rd_we  output  1  committed rd write-enable
rf_pc_we  output  1  committed PC write-enable
rf_cpsr_we  output  1  committed CPSR write-enable
pc_inc  output  1  sequential PC+4 pulse
dmem_req  output  1  data memory request
dmem_we  output  1  1=store, 0=load
dmem_ack  input  1  data access complete
halt_req  input  1  request stop at instruction boundary
halted  output  1  in HALTED state
fault  output  1  sticky fault flag
fault_code  output  2  01 fetch timeout, 10 data timeout, 11 undefined class
state  output  3  FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WRITEBACK=4 HALTED=5 FAULT=6
retired  output  CNT_W  completed-instruction count

Behaviour:
- Sync reset: state=FETCH, inst=0, cond_ok=0, wait counter=0, fault=0, fault_code=00, retired=0. Combinational outputs are gated low while reset=1.
- imem_req = (state==FETCH) & ~reset. dmem_req = (state==MEM). halted = (state==HALTED). rf_*_we and pc_inc are 0 outside WRITEBACK.
- FETCH: imem_req held high until imem_ack sampled high. On ack: inst<=imem_rdata, wait counter cleared, go to DECODE. Acks seen in any other state are ignored.
- Wait counter increments each FETCH/MEM cycle without ack. If it reaches MEM_TIMEOUT with no ack, go to FAULT with fault_code 01 (FETCH) or 10 (MEM). An ack arriving on the MEM_TIMEOUT-th cycle is accepted; ack wins.
- DECODE: exactly 1 cycle for decoder settle. Go to EXECUTE.
- EXECUTE: cond_ok<=cond_pass.
  - If cond_pass=0: go to WRITEBACK (no-op).
  - Else if inst[27:26]==11: go to FAULT, code 11.
  - Else if inst[27:26]==01: go to MEM.
  - Else: go to WRITEBACK.
- MEM: dmem_we = ~inst[20], stable for the whole request. On dmem_ack: go to WRITEBACK, counter cleared.
- WRITEBACK: exactly 1 cycle.
  - rf_rd_we=dec_rd_we&cond_ok
  - rf_cpsr_we=dec_cpsr_we&cond_ok
  - rf_pc_we=dec_pc_we&cond_ok
  - pc_inc=~rf_pc_we
  - retired+=1, including condition-failed instructions; wraps modulo 2^CNT_W.
  - Next state: HALTED if halt_req=1, else FETCH.
- halt_req is sampled only in WRITEBACK. A mid-instruction halt_req does not abort.
- HALTED: no requests issued. Leaves to FETCH on the first cycle halt_req=0.
- FAULT: all requests and enables low. fault=1 and fault_code hold until reset.
- Reset mid-operation (e.g. inside MEM with dmem_req high): dmem_req drops in the reset cycle. No write-enable is issued. Restart is FETCH.
- Latency: non-memory instruction with 1-cycle ack = 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK). Load/store adds MEM cycles.

Test Plan:
- ADD (0xE0810002), imem_ack 1st cycle, dec_rd_we=1 → states 0,1,2,4; rf_rd_we=1 and pc_inc=1 in cycle 4; retired=1.
- LDR (0xE5910000), dmem_ack after 3 cycles → MEM lasts 3 cycles, dmem_we=0; WRITEBACK follows; total 7 cycles.
- Branch with cond_pass=0, dec_pc_we=1 → rf_pc_we=0, pc_inc=1; retired still increments.
- imem_ack never asserted, MEM_TIMEOUT=16 → after 16 FETCH cycles state=6, fault=1, fault_code=01; remains there until reset; ack on cycle 16 instead gives DECODE.
- halt_req raised during EXECUTE → completes WRITEBACK, enters HALTED, imem_req=0; drop halt_req → FETCH next cycle.
- reset asserted in MEM with dmem_req=1 → dmem_req=0 that cycle, no rf_*_we; after release state=FETCH, retired=0.

Source files
------------

// File: rtl/arm_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : arm_ctrl_fsm_if
// Brief    : Control-sequencer bundle: fetch/data handshakes, decoder enables,
//            commit enables and status.
// Revision : 1.0
// ============================================================================
interface arm_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic              imem_req;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       inst;
  logic              cond_pass;
  logic              dec_rd_we;
  logic              dec_pc_we;
  logic              dec_cpsr_we;
  logic              rf_rd_we;
  logic              rf_pc_we;
  logic              rf_cpsr_we;
  logic              pc_inc;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              halt_req;
  logic              halted;
  logic              fault;
  logic [1:0]        fault_code;
  logic [2:0]        state;
  logic [CNT_W-1:0]  retired;

  modport master (
    output imem_req, inst, rf_rd_we, rf_pc_we, rf_cpsr_we, pc_inc,
           dmem_req, dmem_we, halted, fault, fault_code, state, retired,
    input  imem_ack, imem_rdata, cond_pass, dec_rd_we, dec_pc_we,
           dec_cpsr_we, dmem_ack, halt_req
  );

  modport slave (
    input  imem_req, inst, rf_rd_we, rf_pc_we, rf_cpsr_we, pc_inc,
           dmem_req, dmem_we, halted, fault, fault_code, state, retired,
    output imem_ack, imem_rdata, cond_pass, dec_rd_we, dec_pc_we,
           dec_cpsr_we, dmem_ack, halt_req
  );
endinterface
`default_nettype wire

// File: rtl/arm_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : arm_ctrl_fsm
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with
//            handshake timeouts, halt and sticky fault reporting.
// Revision : 1.0
// ============================================================================
module arm_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  arm_ctrl_fsm_if.master bus
);

  localparam logic [2:0] c_FETCH     = 3'd0;
  localparam logic [2:0] c_DECODE    = 3'd1;
  localparam logic [2:0] c_EXECUTE   = 3'd2;
  localparam logic [2:0] c_MEM       = 3'd3;
  localparam logic [2:0] c_WRITEBACK = 3'd4;
  localparam logic [2:0] c_HALTED    = 3'd5;
  localparam logic [2:0] c_FAULT     = 3'd6;

  localparam logic [1:0] c_FC_FETCH = 2'b01;
  localparam logic [1:0] c_FC_DATA  = 2'b10;
  localparam logic [1:0] c_FC_UNDEF = 2'b11;

  // Counter holds cycles already waited; the MEM_TIMEOUT-th cycle sees MEM_TIMEOUT-1.
  localparam int              c_WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [31:0]         r_inst;
  logic                r_cond_ok;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_fault;
  logic [1:0]          r_fault_code;
  logic [CNT_W-1:0]    r_retired;

  logic [2:0]          w_next;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic [1:0]          w_code_nxt;
  logic                w_inst_ld;
  logic                w_in_wb;

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    w_code_nxt = r_fault_code;
    w_inst_ld  = 1'b0;
    case (r_state)
      c_FETCH: begin
        if (bus.imem_ack) begin
          w_next     = c_DECODE;
          w_wait_nxt = '0;
          w_inst_ld  = 1'b1;
        end else if (r_wait == c_WAIT_LAST) begin
          w_next     = c_FAULT;
          w_wait_nxt = '0;
          w_code_nxt = c_FC_FETCH;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      c_DECODE:  w_next = c_EXECUTE;
      c_EXECUTE: begin
        if (!bus.cond_pass) begin
          w_next = c_WRITEBACK;
        end else if (r_inst[27:26] == 2'b11) begin
          w_next     = c_FAULT;
          w_code_nxt = c_FC_UNDEF;
        end else if (r_inst[27:26] == 2'b01) begin
          w_next = c_MEM;
        end else begin
          w_next = c_WRITEBACK;
        end
      end
      c_MEM: begin
        if (bus.dmem_ack) begin
          w_next     = c_WRITEBACK;
          w_wait_nxt = '0;
        end else if (r_wait == c_WAIT_LAST) begin
          w_next     = c_FAULT;
          w_wait_nxt = '0;
          w_code_nxt = c_FC_DATA;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      c_WRITEBACK: w_next = bus.halt_req ? c_HALTED : c_FETCH;
      c_HALTED:    w_next = bus.halt_req ? c_HALTED : c_FETCH;
      c_FAULT:     w_next = c_FAULT;
      default:     w_next = c_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_FETCH;
      r_inst       <= '0;
      r_cond_ok    <= 1'b0;
      r_wait       <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next;
      r_wait       <= w_wait_nxt;
      r_fault_code <= w_code_nxt;
      if (w_next == c_FAULT) begin
        r_fault <= 1'b1;
      end
      if (w_inst_ld) begin
        r_inst <= bus.imem_rdata;
      end
      if (r_state == c_EXECUTE) begin
        r_cond_ok <= bus.cond_pass;
      end
      if (r_state == c_WRITEBACK) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Every combinational output is forced low while reset is held.
  assign w_in_wb = (r_state == c_WRITEBACK) && !reset && r_cond_ok;

  assign bus.imem_req   = (r_state == c_FETCH) && !reset;
  assign bus.dmem_req   = (r_state == c_MEM) && !reset;
  assign bus.dmem_we    = (r_state == c_MEM) && !reset && !r_inst[20];
  assign bus.halted     = (r_state == c_HALTED) && !reset;
  assign bus.rf_rd_we   = w_in_wb && bus.dec_rd_we;
  assign bus.rf_pc_we   = w_in_wb && bus.dec_pc_we;
  assign bus.rf_cpsr_we = w_in_wb && bus.dec_cpsr_we;
  assign bus.pc_inc     = (r_state == c_WRITEBACK) && !reset && !bus.rf_pc_we;

  assign bus.inst       = r_inst;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.state      = r_state;
  assign bus.retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_arm_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_ctrl_fsm
// Brief    : Directed vector table plus hand sequences for timeouts and reset.
// Revision : 1.0
// ============================================================================
module tb_arm_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_ctrl_fsm_if #(.CNT_W(32)) bus ();

  arm_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // in : {rst, imem_ack, cond_pass, dec_rd_we, dec_pc_we, dec_cpsr_we, dmem_ack, halt_req}
  // out: {imem_req, dmem_req, dmem_we, rf_rd_we, rf_pc_we, rf_cpsr_we, pc_inc, halted, fault}
  typedef struct {
    logic [7:0]  in;
    logic [31:0] rdata;
    logic [2:0]  st;
    logic [8:0]  out;
    logic [1:0]  fc;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic [7:0] in, input logic [31:0] rd, input logic [2:0] st,
                     input logic [8:0] out, input logic [1:0] fc, input logic [31:0] ret);
    vec_t v;
    v.in = in; v.rdata = rd; v.st = st; v.out = out; v.fc = fc; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] in, input logic [31:0] rd);
    {reset, bus.imem_ack, bus.cond_pass, bus.dec_rd_we, bus.dec_pc_we,
     bus.dec_cpsr_we, bus.dmem_ack, bus.halt_req} = in;
    bus.imem_rdata = rd;
  endtask

  function automatic logic [8:0] outs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_rd_we, bus.rf_pc_we,
            bus.rf_cpsr_we, bus.pc_inc, bus.halted, bus.fault};
  endfunction

  // Leaves the DUT in FETCH with a clear wait counter, just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    set_in(8'b1000_0000, 32'h0);
    @(negedge clk);
    set_in(8'b0000_0000, 32'h0);
  endtask

  initial begin
    set_in(8'b1000_0000, 32'h0);
    repeat (2) @(posedge clk);

    add(8'b1000_0000, 32'h0,        3'd0, 9'b000000000, 2'd0, 0);
    // ADD, ack on first cycle
    add(8'b0100_0000, 32'hE0810002, 3'd0, 9'b100000000, 2'd0, 0);
    add(8'b0000_0000, 32'h0,        3'd1, 9'b000000000, 2'd0, 0);
    add(8'b0010_0000, 32'h0,        3'd2, 9'b000000000, 2'd0, 0);
    add(8'b0001_0000, 32'h0,        3'd4, 9'b000100100, 2'd0, 0);
    // LDR, data ack in third MEM cycle
    add(8'b0100_0000, 32'hE5910000, 3'd0, 9'b100000000, 2'd0, 1);
    add(8'b0000_0000, 32'h0,        3'd1, 9'b000000000, 2'd0, 1);
    add(8'b0010_0000, 32'h0,        3'd2, 9'b000000000, 2'd0, 1);
    add(8'b0000_0000, 32'h0,        3'd3, 9'b010000000, 2'd0, 1);
    add(8'b0000_0000, 32'h0,        3'd3, 9'b010000000, 2'd0, 1);
    add(8'b0000_0010, 32'h0,        3'd3, 9'b010000000, 2'd0, 1);
    add(8'b0001_0000, 32'h0,        3'd4, 9'b000100100, 2'd0, 1);
    // STR, fetch ack on second cycle, CPSR write only
    add(8'b0000_0000, 32'h0,        3'd0, 9'b100000000, 2'd0, 2);
    add(8'b0100_0000, 32'hE5810000, 3'd0, 9'b100000000, 2'd0, 2);
    add(8'b0000_0000, 32'h0,        3'd1, 9'b000000000, 2'd0, 2);
    add(8'b0010_0000, 32'h0,        3'd2, 9'b000000000, 2'd0, 2);
    add(8'b0000_0010, 32'h0,        3'd3, 9'b011000000, 2'd0, 2);
    add(8'b0000_0100, 32'h0,        3'd4, 9'b000001100, 2'd0, 2);
    // Branch, condition fails
    add(8'b0100_0000, 32'hEA000000, 3'd0, 9'b100000000, 2'd0, 3);
    add(8'b0000_0000, 32'h0,        3'd1, 9'b000000000, 2'd0, 3);
    add(8'b0000_0000, 32'h0,        3'd2, 9'b000000000, 2'd0, 3);
    add(8'b0001_1000, 32'h0,        3'd4, 9'b000000100, 2'd0, 3);
    // Branch taken; stray ack in DECODE must not reload inst
    add(8'b0100_0000, 32'hEA000004, 3'd0, 9'b100000000, 2'd0, 4);
    add(8'b0100_0000, 32'hFFFFFFFF, 3'd1, 9'b000000000, 2'd0, 4);
    add(8'b0010_0000, 32'h0,        3'd2, 9'b000000000, 2'd0, 4);
    add(8'b0000_1000, 32'h0,        3'd4, 9'b000010000, 2'd0, 4);
    // Halt raised in EXECUTE
    add(8'b0100_0000, 32'hE0810002, 3'd0, 9'b100000000, 2'd0, 5);
    add(8'b0000_0000, 32'h0,        3'd1, 9'b000000000, 2'd0, 5);
    add(8'b0010_0001, 32'h0,        3'd2, 9'b000000000, 2'd0, 5);
    add(8'b0001_0001, 32'h0,        3'd4, 9'b000100100, 2'd0, 5);
    add(8'b0100_0001, 32'h0,        3'd5, 9'b000000010, 2'd0, 6);
    add(8'b0000_0000, 32'h0,        3'd5, 9'b000000010, 2'd0, 6);
    // Undefined class faults, stays until reset
    add(8'b0100_0000, 32'hEC000000, 3'd0, 9'b100000000, 2'd0, 6);
    add(8'b0000_0000, 32'h0,        3'd1, 9'b000000000, 2'd0, 6);
    add(8'b0010_0000, 32'h0,        3'd2, 9'b000000000, 2'd0, 6);
    add(8'b0000_0000, 32'h0,        3'd6, 9'b000000001, 2'd3, 6);
    add(8'b0100_0000, 32'h0,        3'd6, 9'b000000001, 2'd3, 6);
    add(8'b1000_0000, 32'h0,        3'd6, 9'b000000001, 2'd3, 6);
    add(8'b0000_0000, 32'h0,        3'd0, 9'b100000000, 2'd0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      set_in(vq[i].in, vq[i].rdata);
      #1;
      chk($sformatf("v%0d.state", i), 32'(bus.state),      32'(vq[i].st));
      chk($sformatf("v%0d.outs", i),  32'(outs()),         32'(vq[i].out));
      chk($sformatf("v%0d.fcode", i), 32'(bus.fault_code), 32'(vq[i].fc));
      chk($sformatf("v%0d.retired", i), bus.retired,       vq[i].ret);
    end

    // Fetch timeout after 16 unacknowledged cycles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_fetch.wait_state", 32'(bus.state), 32'd0);
      chk("to_fetch.imem_req", 32'(bus.imem_req), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("to_fetch.state", 32'(bus.state), 32'd6);
    chk("to_fetch.fault", 32'(bus.fault), 32'd1);
    chk("to_fetch.code", 32'(bus.fault_code), 32'd1);
    chk("to_fetch.imem_req", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("to_fetch.sticky", 32'(bus.state), 32'd6);
    bus.imem_ack = 1'b0;

    // Ack on the 16th fetch cycle wins, then a data timeout
    do_reset();
    for (int i = 0; i < 15; i++) @(negedge clk);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hE5910000;
    #1;
    chk("ack16.state", 32'(bus.state), 32'd0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    chk("ack16.decode", 32'(bus.state), 32'd1);
    chk("ack16.inst", bus.inst, 32'hE5910000);
    @(negedge clk);
    bus.cond_pass = 1'b1;
    @(negedge clk);
    bus.cond_pass = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_mem.state", 32'(bus.state), 32'd3);
      chk("to_mem.dmem_req_we", 32'({bus.dmem_req, bus.dmem_we}), 32'b10);
      @(negedge clk);
    end
    #1;
    chk("to_mem.fault_state", 32'(bus.state), 32'd6);
    chk("to_mem.code", 32'(bus.fault_code), 32'd2);
    chk("to_mem.dmem_req", 32'(bus.dmem_req), 32'd0);

    // Reset while a store request is outstanding
    do_reset();
    set_in(8'b0100_0000, 32'hE5810000);
    @(negedge clk);
    set_in(8'b0000_0000, 32'h0);
    @(negedge clk);
    set_in(8'b0010_0000, 32'h0);
    @(negedge clk);
    set_in(8'b0001_1100, 32'h0);
    #1;
    chk("rstmem.before", 32'({bus.state, bus.dmem_req, bus.dmem_we}), 32'({3'd3, 2'b11}));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmem.outs", 32'(outs()), 32'd0);
    @(negedge clk);
    set_in(8'b0000_0000, 32'h0);
    #1;
    chk("rstmem.state", 32'(bus.state), 32'd0);
    chk("rstmem.retired", bus.retired, 32'd0);
    chk("rstmem.imem_req", 32'(bus.imem_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
